restoring_divider: RTL

Sequential 8-bit restoring divider: the inverse of the lab shift-add multiplier. Latches a dividend and divisor on an Execute request and produces an 8-bit quotient and remainder after a fixed number of shift-subtract iterations. Runs once per Execute press, then holds the result until Execute is released. It sits behind the same synchronized switch and button inputs as the multiplier; its results drive the hex display.

---
 rtl/restoring_divider.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// Sequential 8-bit restoring divider: one shift-subtract step per cycle, result held until Execute drops.
// Optional macro DIV_SIGNED_EN selects two's-complement operands (truncating division); default is unsigned.
module restoring_divider (
    input  logic       Clk_i,
    input  logic       Reset_n_i,
    input  logic       Execute_i,
    input  logic [7:0] Dividend_i,
    input  logic [7:0] Divisor_i,
    output logic [7:0] Quotient_o,
    output logic [7:0] Remainder_o,
    output logic       Busy_o,
    output logic       Done_o,
    output logic       Div_By_Zero_o
);

    typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  r_q, r_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  d_q, d_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [9:0]  shifted;
    logic [9:0]  diff;
    logic        fits;
    logic [7:0]  rem_src;
    logic [7:0]  quot_fix;
    logic [7:0]  rem_fix;
    logic [7:0]  dividend_in;
    logic [7:0]  divisor_in;

    // {R,Q} shifted left by one; R never exceeds the divisor, so bit 9 stays clear.
    assign shifted = {r_q, q_q[7]};
    assign diff    = shifted - {2'b00, d_q};
    assign fits    = ~diff[9];
    // On a zero divisor Q still holds the untouched (magnitude of the) dividend.
    assign rem_src = (state_q == CHECK) ? q_q : r_q[7:0];

`ifdef DIV_SIGNED_EN
    logic sn_q, sn_d;
    logic sd_q, sd_d;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            sn_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            sn_q <= sn_d;
            sd_q <= sd_d;
        end
    end

    always_comb begin
        sn_d = sn_q;
        sd_d = sd_q;
        if (state_q == IDLE && Execute_i) begin
            sn_d = Dividend_i[7];
            sd_d = Divisor_i[7];
        end
    end

    assign dividend_in = Dividend_i[7] ? (~Dividend_i + 8'd1) : Dividend_i;
    assign divisor_in  = Divisor_i[7]  ? (~Divisor_i  + 8'd1) : Divisor_i;
    assign quot_fix    = (sn_q ^ sd_q) ? (~q_q + 8'd1) : q_q;
    assign rem_fix     = sn_q ? (~rem_src + 8'd1) : rem_src;
`else
    assign dividend_in = Dividend_i;
    assign divisor_in  = Divisor_i;
    assign quot_fix    = q_q;
    assign rem_fix     = rem_src;
`endif

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= IDLE;
            r_q     <= 9'd0;
            q_q     <= 8'd0;
            d_q     <= 8'd0;
            cnt_q   <= 3'd0;
            dz_q    <= 1'b0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (Execute_i) begin
                    q_d     = dividend_in;
                    d_d     = divisor_in;
                    r_d     = 9'd0;
                    cnt_d   = 3'd0;
                    dz_d    = 1'b0;
                    state_d = CHECK;
                end
            end
            // Two cycles: register the zero compare, then branch on it.
            CHECK: begin
                if (cnt_q == 3'd0) begin
                    dz_d  = (d_q == 8'd0);
                    cnt_d = 3'd1;
                end else begin
                    cnt_d = 3'd0;
                    if (dz_q) begin
                        quot_d  = 8'hFF;
                        rem_d   = rem_fix;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                r_d   = fits ? diff[8:0] : shifted[8:0];
                q_d   = {q_q[6:0], fits};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = quot_fix;
                rem_d   = rem_fix;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (!Execute_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Quotient_o    = quot_q;
    assign Remainder_o   = rem_q;
    assign Div_By_Zero_o = dbz_q;
    assign Busy_o        = (state_q == CHECK) || (state_q == ITER) || (state_q == FIX);
    assign Done_o        = (state_q == DONE);

endmodule
